cla_add_sequencer: RTL and testbench
====================================

Name: cla_add_sequencer

Overview:
- Valid/ready operand sequencer that wraps the 64-bit gate-level CLA adder.
- Registers A, B and Cin from an upstream producer and holds them stable on the adder inputs.
- Waits a programmable number of settle cycles to cover the adder's gate-delay path, then captures S and Cout into a result register.
- Presents the result to a downstream consumer with backpressure. The adder itself stays combinational and is instantiated beside this block.

Parameters:
- WIDTH, 64: operand, sum and carry-vector width; must match the adder.
- SETTLE_CYCLES, 4: clock cycles between operand launch and result capture; legal range 1..255.
- CNT_W, 8: settle counter width; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: synchronous active-low reset.
- in_valid, in, 1: upstream operand valid.
- in_ready, out, 1: block can accept operands.
- in_a, in, WIDTH: operand A.
- in_b, in, WIDTH: operand B.
- in_cin, in, 1: carry in.
- cla_a, out, WIDTH: registered A driven to the adder.
- cla_b, out, WIDTH: registered B driven to the adder.
- cla_cin, out, 1: registered Cin driven to the adder.
- cla_s, in, WIDTH: adder sum.
- cla_carry, in, WIDTH: adder per-bit carry vector; bit i is the carry out of bit i.
- cla_cout, in, 1: adder carry out.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- out_sum, out, WIDTH: captured sum.
- out_cout, out, 1: captured carry out.
- busy, out, 1: high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: state=IDLE, cla_a=0, cla_b=0, cla_cin=0, out_sum=0, out_cout=0, out_valid=0, counter=0.
- Combinational outputs: in_ready = (state==IDLE); busy = !in_ready. in_ready is 1 in the first cycle after reset deasserts.
- FSM states: IDLE, SETTLE, DONE.
- IDLE:
  - On in_valid, latch in_a, in_b and in_cin into cla_a, cla_b and cla_cin.
  - Load the counter with SETTLE_CYCLES-1 and go to SETTLE.
  - Without in_valid, all registers hold.
- SETTLE:
  - While counter!=0, decrement it.
  - When counter==0, capture cla_s into out_sum and cla_cout into out_cout, set out_valid=1, and go to DONE.
- DONE:
  - out_valid=1; out_sum and out_cout are held stable.
  - On out_ready, clear out_valid on the next edge and go to IDLE.
- Latency: if operands are accepted at edge k, out_valid rises at edge k+SETTLE_CYCLES.
- Throughput: one operation per SETTLE_CYCLES+2 cycles at minimum. There is no back-to-back accept from DONE.
- Operand stability: cla_a, cla_b and cla_cin change only on acceptance in IDLE. They stay stable through capture and through DONE.
- in_valid in SETTLE or DONE is ignored; in_ready is 0, so nothing is dropped.
- A stalled result (out_ready=0) persists indefinitely unchanged.
- SETTLE_CYCLES=1: capture occurs on the edge after acceptance.
- Reset mid-operation: the transaction is discarded, no out_valid is produced, and all reset values apply on the next edge.
- Arithmetic: none is done in this block. The sum is exactly what the adder produces, and the carry is not re-computed.

Optional Feature:
- Macro: CLA_SEQ_OVF_EN.
- When defined:
  - Adds output out_ovf (1 bit), reset 0.
  - On capture it loads cla_carry[WIDTH-1] ^ cla_carry[WIDTH-2] (signed two's-complement overflow).
  - It is held and cleared with the same rules as out_sum.
- When undefined: the port and register are absent and cla_carry is unused. There is no other behavioural difference.

Decomposition:
- Package cla_seq_pkg holds:
  - state enum {IDLE, SETTLE, DONE};
  - CLA_WIDTH = 64;
  - default SETTLE_CYCLES constant.
- Sub-module cla_settle_timer:
  - inputs: load, load value;
  - output: expire flag;
  - owns the down-counter.
- The FSM and the capture registers stay in the top module.

Test Plan:
- Carry-ripple case: A=0, B=64'hFFFF_FFFF_FFFF_FFFF, Cin=1, out_ready=1.
  - out_valid goes high exactly 4 edges after acceptance.
  - out_sum=0 and out_cout=1.
- No-carry case: same A and B with Cin=0 → out_sum=64'hFFFF_FFFF_FFFF_FFFF, out_cout=0.
- Backpressure: A=1, B=1, out_ready held 0 for 10 cycles.
  - out_valid stays 1 and out_sum=2 is unchanged throughout.
  - in_ready stays 0 and a concurrent in_valid is not accepted.
  - Releasing out_ready returns the block to IDLE after 1 edge.
- Mid-operation reset: rst_n=0 at SETTLE cycle 2.
  - Next cycle: out_valid=0, busy=0, cla_a=0.
  - No result is ever emitted for that operation.
- SETTLE_CYCLES=1 build: A=5, B=3 → out_valid one edge after acceptance, out_sum=8.
- CLA_SEQ_OVF_EN build:
  - A=64'h7FFF_FFFF_FFFF_FFFF, B=1 → out_ovf=1, out_sum=64'h8000_0000_0000_0000.
  - A=1, B=1 → out_ovf=0.

Source files
------------

// File: rtl/cla_add_sequencer_pkg.sv
// rtl/cla_add_sequencer_pkg.sv - shared types and constants for the CLA operand sequencer
// State encoding and default sizing used by the sequencer, its timer and interface.
package cla_seq_pkg;

    localparam int CLA_WIDTH         = 64;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/cla_add_sequencer_if.sv
// rtl/cla_add_sequencer_if.sv - operand/result handshake bundle for the CLA sequencer
// Optional out_ovf lane present only when CLA_SEQ_OVF_EN is defined.
interface cla_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef CLA_SEQ_OVF_EN
    logic             out_ovf;
`endif

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
`ifdef CLA_SEQ_OVF_EN
        , input out_ovf
`endif
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
`ifdef CLA_SEQ_OVF_EN
        , output out_ovf
`endif
    );

endinterface

// File: rtl/cla_add_sequencer_settle_timer.sv
// rtl/cla_add_sequencer_settle_timer.sv - settle down-counter for the CLA sequencer
// Loads a count, decrements to zero and holds; expire is high whenever the count is zero.
module cla_settle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expire
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/cla_add_sequencer.sv
// rtl/cla_add_sequencer.sv - valid/ready operand sequencer around a combinational CLA adder
// Optional signed-overflow output enabled by defining CLA_SEQ_OVF_EN.
module cla_add_sequencer
    import cla_seq_pkg::*;
#(
    parameter int WIDTH         = CLA_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    cla_seq_if.slave         bus,
    output logic [WIDTH-1:0] cla_a,
    output logic [WIDTH-1:0] cla_b,
    output logic             cla_cin,
    input  logic [WIDTH-1:0] cla_s,
    input  logic [WIDTH-1:0] cla_carry,
    input  logic             cla_cout,
    output logic             busy
);

    seq_state_e       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_out_valid;
`ifdef CLA_SEQ_OVF_EN
    logic             r_ovf;
`endif

    logic             w_in_ready;
    logic             w_load;
    logic             w_expire;
    logic             w_unused_carry;

    assign w_in_ready = (r_state == IDLE);
    assign w_load     = w_in_ready && bus.in_valid;

    // Only the top two carries feed overflow; the rest of the vector is observed but unused.
    assign w_unused_carry = ^cla_carry;

    cla_settle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (CNT_W'(SETTLE_CYCLES - 1)),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.in_a;
                        r_b     <= bus.in_b;
                        r_cin   <= bus.in_cin;
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Operands have been stable for SETTLE_CYCLES edges; adder output is trusted now.
                    if (w_expire) begin
                        r_sum       <= cla_s;
                        r_cout      <= cla_cout;
`ifdef CLA_SEQ_OVF_EN
                        r_ovf       <= cla_carry[WIDTH-1] ^ cla_carry[WIDTH-2];
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_cout;
`ifdef CLA_SEQ_OVF_EN
    assign bus.out_ovf   = r_ovf;
`endif

    assign cla_a   = r_a;
    assign cla_b   = r_b;
    assign cla_cin = r_cin;
    assign busy    = !w_in_ready;

endmodule

// File: tb/tb_cla_add_sequencer.sv
// tb/tb_cla_add_sequencer.sv - directed self-checking bench for cla_add_sequencer
// Two instances (SETTLE_CYCLES=4 and 1), each beside a behavioural ripple adder.
`timescale 1ns/1ps
module tb_cla_add_sequencer;

    localparam int W = 64;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    cla_seq_if #(.WIDTH(W)) b4 ();
    cla_seq_if #(.WIDTH(W)) b1 ();

    logic [W-1:0] a4, bb4, s4, c4, a1, bb1, s1, c1;
    logic         cin4, cout4, busy4, cin1, cout1, busy1;

    cla_add_sequencer #(.WIDTH(W), .SETTLE_CYCLES(4), .CNT_W(8)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (b4),
        .cla_a     (a4),
        .cla_b     (bb4),
        .cla_cin   (cin4),
        .cla_s     (s4),
        .cla_carry (c4),
        .cla_cout  (cout4),
        .busy      (busy4)
    );

    cla_add_sequencer #(.WIDTH(W), .SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (b1),
        .cla_a     (a1),
        .cla_b     (bb1),
        .cla_cin   (cin1),
        .cla_s     (s1),
        .cla_carry (c1),
        .cla_cout  (cout1),
        .busy      (busy1)
    );

    always_comb begin
        logic cc;
        cc = cin4;
        s4 = '0;
        c4 = '0;
        for (int i = 0; i < W; i++) begin
            s4[i] = a4[i] ^ bb4[i] ^ cc;
            cc    = (a4[i] & bb4[i]) | ((a4[i] ^ bb4[i]) & cc);
            c4[i] = cc;
        end
        cout4 = cc;
    end

    always_comb begin
        logic cc;
        cc = cin1;
        s1 = '0;
        c1 = '0;
        for (int i = 0; i < W; i++) begin
            s1[i] = a1[i] ^ bb1[i] ^ cc;
            cc    = (a1[i] & bb1[i]) | ((a1[i] ^ bb1[i]) & cc);
            c1[i] = cc;
        end
        cout1 = cc;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand set for a single edge, then counts edges until out_valid (bounded).
    task automatic run_op(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, output int lat);
        if (sel == 4) begin
            b4.in_a = a; b4.in_b = b; b4.in_cin = cin; b4.in_valid = 1'b1;
        end else begin
            b1.in_a = a; b1.in_b = b; b1.in_cin = cin; b1.in_valid = 1'b1;
        end
        tick();
        b4.in_valid = 1'b0;
        b1.in_valid = 1'b0;
        lat = 0;
        while (!((sel == 4) ? b4.out_valid : b1.out_valid) && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bad;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        b4.in_valid = 1'b0; b4.in_a = '0; b4.in_b = '0; b4.in_cin = 1'b0; b4.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.in_a = '0; b1.in_b = '0; b1.in_cin = 1'b0; b1.out_ready = 1'b0;
        repeat (3) tick();

        check("rst_out_valid", W'(b4.out_valid), W'(0));
        check("rst_busy", W'(busy4), W'(0));
        check("rst_cla_a", a4, '0);
        check("rst_out_sum", b4.out_sum, '0);
        rst_n = 1'b1;
        check("rst_in_ready", W'(b4.in_ready), W'(1));

        // Carry ripples through every bit
        b4.out_ready = 1'b1;
        run_op(4, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, lat);
        check("ripple_latency", W'(lat), W'(4));
        check("ripple_sum", b4.out_sum, 64'h0);
        check("ripple_cout", W'(b4.out_cout), W'(1));
        check("ripple_busy", W'(busy4), W'(1));
        check("ripple_cla_b_stable", bb4, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        check("ripple_to_idle", W'(b4.in_ready), W'(1));
        check("ripple_valid_clr", W'(b4.out_valid), W'(0));

        run_op(4, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat);
        check("nocarry_latency", W'(lat), W'(4));
        check("nocarry_sum", b4.out_sum, 64'hFFFF_FFFF_FFFF_FFFF);
        check("nocarry_cout", W'(b4.out_cout), W'(0));
        tick();

        // Backpressure with a competing request held on the input
        b4.out_ready = 1'b0;
        run_op(4, 64'h1, 64'h1, 1'b0, lat);
        check("bp_latency", W'(lat), W'(4));
        b4.in_a = 64'h9; b4.in_b = 64'h9; b4.in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (b4.out_valid !== 1'b1 || b4.out_sum !== 64'h2 || b4.in_ready !== 1'b0 || a4 !== 64'h1)
                bad++;
        end
        check("bp_hold_cycles_bad", W'(bad), W'(0));
        check("bp_sum", b4.out_sum, 64'h2);
        b4.in_valid = 1'b0;
        b4.out_ready = 1'b1;
        tick();
        check("bp_release_idle", W'(b4.in_ready), W'(1));
        check("bp_release_valid", W'(b4.out_valid), W'(0));
        check("bp_not_accepted", a4, 64'h1);

        // Reset in the middle of SETTLE
        b4.in_a = 64'h5; b4.in_b = 64'h7; b4.in_cin = 1'b0; b4.in_valid = 1'b1;
        tick();
        b4.in_valid = 1'b0;
        tick();
        check("midrst_busy_before", W'(busy4), W'(1));
        rst_n = 1'b0;
        tick();
        check("midrst_out_valid", W'(b4.out_valid), W'(0));
        check("midrst_busy", W'(busy4), W'(0));
        check("midrst_cla_a", a4, '0);
        check("midrst_out_sum", b4.out_sum, '0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (b4.out_valid !== 1'b0) bad++;
        end
        check("midrst_no_result", W'(bad), W'(0));

        // Single settle cycle instance
        b1.out_ready = 1'b1;
        run_op(1, 64'h5, 64'h3, 1'b0, lat);
        check("s1_latency", W'(lat), W'(1));
        check("s1_sum", b1.out_sum, 64'h8);
        check("s1_cout", W'(b1.out_cout), W'(0));
        tick();
        check("s1_idle", W'(b1.in_ready), W'(1));

`ifdef CLA_SEQ_OVF_EN
        run_op(4, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
        check("ovf_sum", b4.out_sum, 64'h8000_0000_0000_0000);
        check("ovf_set", W'(b4.out_ovf), W'(1));
        tick();
        run_op(4, 64'h1, 64'h1, 1'b0, lat);
        check("ovf_clear_sum", b4.out_sum, 64'h2);
        check("ovf_clear", W'(b4.out_ovf), W'(0));
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
